// File: rtl/data_bus_responder_if.sv
// Word-addressed data bus between the core (master) and the responder (slave).
// Read data flows back combinationally; writes commit on the responder's clock edge.
interface data_bus_responder_if;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;

  modport master (
    output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    input  bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    output bus_read_data
  );
endinterface

// File: rtl/data_bus_responder.sv
// Data bus responder: byte-writable RAM, MMIO page (console FIFO, cycle counter, tohost), error flag.
// Reads are 0-cycle combinational, writes commit in 1 edge; the console FIFO drops bytes when full (sticky overflow).
module data_bus_responder #(
  parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
  parameter int unsigned RAM_WORDS  = 16384,
  parameter logic [31:0] MMIO_BASE  = 32'h4000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  output logic                 console_valid,
  output logic [7:0]           console_data,
  input  logic                 console_ready,
  output logic                 tohost_valid,
  output logic [31:0]          tohost_data,
  output logic                 bus_error
);
  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0] mem_q [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [63:0]   cyc_q, cyc_d;
  logic [31:0]   hi_shadow_q, hi_shadow_d;
  logic          tohost_vld_q, tohost_vld_d;
  logic [31:0]   tohost_dat_q, tohost_dat_d;
  logic          err_q, err_d;

  logic [31:0] ram_off;
  logic [AW-1:0] ram_idx;
  logic ram_hit, mmio_hit;
  logic [9:0] mmio_word;
  logic re, we, fifo_full, fifo_empty, pop, push_req, push;
  logic unused_bits;

  assign re        = bus.bus_read_enable;
  assign we        = bus.bus_write_enable;
  assign ram_off   = bus.bus_address - RAM_BASE;
  assign ram_idx   = ram_off[AW+1:2];
  assign ram_hit   = (bus.bus_address >= RAM_BASE) && ({1'b0, ram_off} < RAM_BYTES);
  assign mmio_hit  = (bus.bus_address[31:12] == MMIO_BASE[31:12]);
  assign mmio_word = bus.bus_address[11:2];
  assign unused_bits = ^{ram_off[1:0]};

  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = console_valid && console_ready;
  assign push_req   = we && mmio_hit && (mmio_word == 10'd0) && bus.bus_byte_enable[0];
  // A full FIFO still accepts the byte when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  assign console_valid = !fifo_empty;
  assign console_data  = console_valid ? fifo_q[rd_ptr_q] : 8'h00;
  assign tohost_valid  = tohost_vld_q;
  assign tohost_data   = tohost_dat_q;
  assign bus_error     = err_q;

  always_comb begin
    bus.bus_read_data = 32'h0;
    if (re) begin
      if (ram_hit) begin
        bus.bus_read_data = mem_q[ram_idx];
      end else if (mmio_hit) begin
        case (mmio_word)
          10'd1:   bus.bus_read_data = {29'b0, overflow_q, fifo_full, fifo_empty};
          10'd2:   bus.bus_read_data = cyc_q[31:0];
          10'd3:   bus.bus_read_data = hi_shadow_q;
          default: bus.bus_read_data = 32'h0;
        endcase
      end
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    cyc_d        = cyc_q + 64'd1;
    hi_shadow_d  = hi_shadow_q;
    tohost_vld_d = tohost_vld_q;
    tohost_dat_d = tohost_dat_q;
    err_d        = err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    if (we && mmio_hit && (mmio_word == 10'd1) && bus.bus_write_data[2]) overflow_d = 1'b0;
    if (push_req && !push) overflow_d = 1'b1;

    if (re && mmio_hit && (mmio_word == 10'd2)) hi_shadow_d = cyc_q[63:32];

    if (we && mmio_hit && (mmio_word == 10'd4) && !tohost_vld_q) begin
      tohost_vld_d = 1'b1;
      tohost_dat_d = bus.bus_write_data;
    end

    if ((re || we) && !ram_hit && !mmio_hit) err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      cyc_q        <= 64'h0;
      hi_shadow_q  <= 32'h0;
      tohost_vld_q <= 1'b0;
      tohost_dat_q <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      cyc_q        <= cyc_d;
      hi_shadow_q  <= hi_shadow_d;
      tohost_vld_q <= tohost_vld_d;
      tohost_dat_q <= tohost_dat_d;
      err_q        <= err_d;
    end
  end

  // Storage arrays are deliberately unreset; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    if (we && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.bus_byte_enable[b]) mem_q[ram_idx][8*b +: 8] <= bus.bus_write_data[8*b +: 8];
      end
    end
    if (push) fifo_q[wr_ptr_q] <= bus.bus_write_data[7:0];
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: vector table for RAM/MMIO decode, hand sequences for FIFO, counter, tohost, reset.
module tb_data_bus_responder;
  localparam logic [31:0] MMIO   = 32'h4000_0000;
  localparam logic [31:0] STATUS = 32'h4000_0004;
  localparam logic [31:0] CYC_LO = 32'h4000_0008;
  localparam logic [31:0] CYC_HI = 32'h4000_000C;
  localparam logic [31:0] TOHOST = 32'h4000_0010;

  logic clock, reset, console_ready;
  logic console_valid, tohost_valid, bus_error;
  logic [7:0] console_data;
  logic [31:0] tohost_data;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  data_bus_responder_if bus_if ();

  data_bus_responder dut (
    .clock(clock), .reset(reset), .bus(bus_if.slave),
    .console_valid(console_valid), .console_data(console_data), .console_ready(console_ready),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data), .bus_error(bus_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drives one bus cycle from posedge+1, samples read data at negedge, returns at next posedge+1.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic rd_en, input logic wr_en, output logic [31:0] rd);
    bus_if.bus_address      = a;
    bus_if.bus_write_data   = d;
    bus_if.bus_byte_enable  = be;
    bus_if.bus_read_enable  = rd_en;
    bus_if.bus_write_enable = wr_en;
    @(negedge clock);
    rd = bus_if.bus_read_data;
    @(posedge clock);
    #1;
    bus_if.bus_read_enable  = 1'b0;
    bus_if.bus_write_enable = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic accept);
    logic [31:0] rd;
    if (accept) exp_q.push_back(b);
    step(MMIO, {24'h0, b}, 4'b0001, 1'b0, 1'b1, rd);
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    step(a, 32'h0, 4'h0, 1'b1, 1'b0, rd);
    check(name, rd, exp);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || console_valid) && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_done", {63'h0, (exp_q.size() == 0 && !console_valid)}, 64'h1);
  endtask

  // Scoreboard: a head transfer happens on the edge after a negedge where valid && ready.
  always @(negedge clock) begin
    if (!reset && console_valid && console_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL console_pop: got byte %h, required no byte", console_data);
      end else begin
        check("console_pop", {56'h0, console_data}, {56'h0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        re;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd;

    tbl[0]  = '{32'h8000_0010, 32'hAABB_CCDD, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
    tbl[1]  = '{32'h8000_0010, 32'h1122_3344, 4'b0101, 1'b1, 1'b1, 32'hAABB_CCDD};
    tbl[2]  = '{32'h8000_0010, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'hAA22_CC44};
    tbl[3]  = '{32'h8000_0013, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'hAA22_CC44};
    tbl[4]  = '{32'h8000_0010, 32'hEE00_0000, 4'b1000, 1'b0, 1'b1, 32'h0000_0000};
    tbl[5]  = '{32'h8000_0010, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'hEE22_CC44};
    tbl[6]  = '{32'h8000_FFFC, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
    tbl[7]  = '{32'h8000_FFFC, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h1234_5678};
    tbl[8]  = '{32'h8000_0000, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
    tbl[9]  = '{32'h4000_0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};
    tbl[10] = '{32'h4000_0004, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0001};
    tbl[11] = '{32'h4000_0020, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b1, 32'h0000_0000};
    tbl[12] = '{32'h4000_0014, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};
    tbl[13] = '{32'h8000_0010, 32'h5555_5555, 4'b1111, 1'b0, 1'b0, 32'h0000_0000};
    tbl[14] = '{32'h8000_0010, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'hEE22_CC44};
    tbl[15] = '{32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};

    reset = 1'b1;
    console_ready = 1'b0;
    bus_if.bus_address = 32'h0;
    bus_if.bus_write_data = 32'h0;
    bus_if.bus_byte_enable = 4'h0;
    bus_if.bus_read_enable = 1'b0;
    bus_if.bus_write_enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_console_valid", {63'h0, console_valid}, 64'h0);
    check("rst_console_data", {56'h0, console_data}, 64'h0);
    check("rst_tohost_valid", {63'h0, tohost_valid}, 64'h0);
    check("rst_tohost_data", {32'h0, tohost_data}, 64'h0);
    check("rst_bus_error", {63'h0, bus_error}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].re, tbl[i].we, rd);
      check($sformatf("tbl[%0d]", i), {32'h0, rd}, {32'h0, tbl[i].exp});
    end
    check("no_error_mapped", {63'h0, bus_error}, 64'h0);

    // Fill to full, then overflow on the 9th byte.
    for (int b = 8'h41; b <= 8'h48; b++) push_byte(8'(b), 1'b1);
    read_chk("status_full", STATUS, 32'h2);
    check("head_valid", {63'h0, console_valid}, 64'h1);
    check("head_data", {56'h0, console_data}, 64'h41);
    push_byte(8'h49, 1'b0);
    read_chk("status_overflow", STATUS, 32'h6);
    console_ready = 1'b1;
    wait_drain(30);
    read_chk("status_drained", STATUS, 32'h5);
    step(STATUS, 32'h4, 4'b1111, 1'b0, 1'b1, rd);
    read_chk("status_ovf_clr", STATUS, 32'h1);

    // Full FIFO with a simultaneous push and pop.
    console_ready = 1'b0;
    for (int b = 8'h61; b <= 8'h68; b++) push_byte(8'(b), 1'b1);
    read_chk("status_full2", STATUS, 32'h2);
    console_ready = 1'b1;
    push_byte(8'h5A, 1'b1);
    read_chk("status_pushpop", STATUS, 32'h2);
    wait_drain(30);
    read_chk("status_empty2", STATUS, 32'h1);
    console_ready = 1'b0;

    // Counter snapshot across the 32-bit carry.
    force dut.cyc_q = 64'h0000_0001_FFFF_FFFF;
    bus_if.bus_address = CYC_LO;
    bus_if.bus_read_enable = 1'b1;
    @(negedge clock);
    check("cyc_lo", {32'h0, bus_if.bus_read_data}, 64'hFFFF_FFFF);
    release dut.cyc_q;
    @(posedge clock);
    #1;
    bus_if.bus_read_enable = 1'b0;
    read_chk("cyc_hi_shadow", CYC_HI, 32'h0000_0001);

    // tohost captures only the first write; unmapped access sets a sticky error.
    step(TOHOST, 32'h1, 4'b1111, 1'b0, 1'b1, rd);
    check("tohost_valid", {63'h0, tohost_valid}, 64'h1);
    check("tohost_data1", {32'h0, tohost_data}, 64'h1);
    step(TOHOST, 32'h3, 4'b1111, 1'b0, 1'b1, rd);
    check("tohost_data_kept", {32'h0, tohost_data}, 64'h1);
    check("err_before", {63'h0, bus_error}, 64'h0);
    read_chk("unmapped_rd", 32'h1000_0000, 32'h0);
    check("err_set", {63'h0, bus_error}, 64'h1);
    step(32'h8001_0000, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1, rd);
    read_chk("ram_end_no_alias", 32'h8000_0000, 32'h0);
    read_chk("ram_end_rd", 32'h8001_0000, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    check("err_sticky", {63'h0, bus_error}, 64'h1);

    // Async reset between edges with bytes queued.
    for (int b = 8'h71; b <= 8'h73; b++) push_byte(8'(b), 1'b1);
    check("queued_valid", {63'h0, console_valid}, 64'h1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_console_valid", {63'h0, console_valid}, 64'h0);
    check("arst_console_data", {56'h0, console_data}, 64'h0);
    check("arst_bus_error", {63'h0, bus_error}, 64'h0);
    check("arst_tohost_valid", {63'h0, tohost_valid}, 64'h0);
    check("arst_tohost_data", {32'h0, tohost_data}, 64'h0);
    exp_q.delete();
    #1;
    reset = 1'b0;
    read_chk("cyc_restart0", CYC_LO, 32'h0);
    read_chk("cyc_restart1", CYC_LO, 32'h1);
    read_chk("status_after_rst", STATUS, 32'h1);
    read_chk("hi_after_rst", CYC_HI, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
